// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control/data inputs and registered outputs.
// Optional parity output present when UNIV_SHIFT_REG_PARITY_EN is defined.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             shift_out;
    logic             zero;
`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic             parity;
`endif

    modport master (
`ifdef UNIV_SHIFT_REG_PARITY_EN
        input  parity,
`endif
        output en, mode, d, sin,
        input  q, q_bar, shift_out, zero
    );

    modport slave (
`ifdef UNIV_SHIFT_REG_PARITY_EN
        output parity,
`endif
        input  en, mode, d, sin,
        output q, q_bar, shift_out, zero
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Multi-mode WIDTH-bit storage/shift register with registered q, q_bar, shift_out and zero.
// Define UNIV_SHIFT_REG_PARITY_EN to add a registered parity output.
module univ_shift_reg #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic             clk,
    input logic             reset,
    univ_shift_reg_if.slave bus
);
    typedef enum logic [2:0] {
        ModeHold = 3'b000,
        ModeLoad = 3'b001,
        ModeShl  = 3'b010,
        ModeShr  = 3'b011,
        ModeRol  = 3'b100,
        ModeRor  = 3'b101,
        ModeAsr  = 3'b110,
        ModeClr  = 3'b111
    } mode_e;

    if (WIDTH < 1 || WIDTH > 64) begin : gen_bad_width
        $error("univ_shift_reg: WIDTH must be in 1..64");
    end

    logic [WIDTH-1:0] q_q, q_d, q_bar_q;
    logic             so_q, so_d, zero_q;
    logic [WIDTH-1:0] shl_val, shr_val, rol_val, ror_val, asr_val;
    logic             msb, lsb;

    // Single-bit registers have no interior bits, so every shift collapses onto q or sin.
    if (WIDTH == 1) begin : gen_w1
        assign shl_val = bus.sin;
        assign shr_val = bus.sin;
        assign rol_val = q_q;
        assign ror_val = q_q;
        assign asr_val = q_q;
        assign msb     = q_q[0];
        assign lsb     = q_q[0];
    end else begin : gen_wn
        assign shl_val = {q_q[WIDTH-2:0], bus.sin};
        assign shr_val = {bus.sin, q_q[WIDTH-1:1]};
        assign rol_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        assign ror_val = {q_q[0], q_q[WIDTH-1:1]};
        assign asr_val = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        assign msb     = q_q[WIDTH-1];
        assign lsb     = q_q[0];
    end

    always_comb begin
        q_d  = q_q;
        so_d = so_q;
        if (bus.en) begin
            unique case (mode_e'(bus.mode))
                ModeHold: ;
                ModeLoad: q_d = bus.d;
                ModeShl:  begin q_d = shl_val; so_d = msb; end
                ModeShr:  begin q_d = shr_val; so_d = lsb; end
                ModeRol:  begin q_d = rol_val; so_d = msb; end
                ModeRor:  begin q_d = ror_val; so_d = lsb; end
                ModeAsr:  begin q_d = asr_val; so_d = lsb; end
                ModeClr:  begin q_d = '0;      so_d = 1'b0; end
                default:  ;
            endcase
        end
    end

    // Derived outputs are registered from q_d so they align with q on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= RESET_VAL;
            q_bar_q <= ~RESET_VAL;
            so_q    <= 1'b0;
            zero_q  <= (RESET_VAL == '0);
        end else begin
            q_q     <= q_d;
            q_bar_q <= ~q_d;
            so_q    <= so_d;
            zero_q  <= (q_d == '0);
        end
    end

`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= ^RESET_VAL;
        end else begin
            parity_q <= ^q_d;
        end
    end

    assign bus.parity = parity_q;
`endif

    assign bus.q         = q_q;
    assign bus.q_bar     = q_bar_q;
    assign bus.shift_out = so_q;
    assign bus.zero      = zero_q;
endmodule
